// File: rtl/prio_encoder_pipe.sv
// -----------------------------------------------------------------------------
// prio_encoder_pipe
//   Registered N-to-log2(N) priority encoder with a valid/ready handshake on
//   both sides. A main register drives the outputs; a skid register absorbs
//   one extra accepted vector. This lets in_ready come straight from a flop
//   rather than depending combinationally on out_ready.
//
// Parameters
//   N        input vector width (power of two, >= 2)
//   PRIO_HI  1: the highest set index wins, 0: the lowest set index wins
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_vec is valid
//   in_ready   block can accept (registered)
//   in_vec     request / one-hot vector
//   out_valid  out_* fields are valid
//   out_ready  consumer accepts the current output
//   out_code   index of the winning set bit
//   out_zero   in_vec was all zeros
//   out_multi  more than one bit of in_vec was set
// -----------------------------------------------------------------------------
module prio_encoder_pipe #(
    parameter int N       = 4,
    parameter bit PRIO_HI = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_code,
    output logic                 out_zero,
    output logic                 out_multi
);

    localparam int W = $clog2(N);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [W-1:0] code;
        logic         zero;
        logic         multi;
    } enc_t;

    // Scan every bit once. With PRIO_HI the last set bit seen overwrites the
    // code (highest index wins); otherwise only the first set bit is kept.
    function automatic enc_t encode(input logic [N-1:0] v);
        enc_t        r;
        int unsigned cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                cnt = cnt + 1;
                if (PRIO_HI || (cnt == 1)) begin
                    r.code = W'(i);
                end
            end
        end
        r.zero  = (cnt == 0);
        r.multi = (cnt > 1);
        return r;
    endfunction

    logic [1:0] state_q, state_d;
    enc_t       main_q, main_d;
    enc_t       skid_q, skid_d;
    logic       in_ready_q, in_ready_d;

    logic       accept;
    logic       drain;
    enc_t       enc_in;

    assign enc_in = encode(in_vec);
    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = enc_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = enc_in;
                end else if (accept) begin
                    skid_d  = enc_in;
                    state_d = ST_TWO;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Registered ready: look ahead at the next state.
        in_ready_d = (state_d != ST_TWO);
    end

    // Data registers are reset as well so out_* read as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_code  = main_q.code;
    assign out_zero  = main_q.zero;
    assign out_multi = main_q.multi;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_prio_encoder_pipe
//   Drives two encoders (PRIO_HI=1 and PRIO_HI=0) from the same stimulus.
//   The driver pushes the expected result for each accepted vector into one
//   queue per instance; a monitor per instance pops and compares whenever an
//   output transfer happens, and checks that outputs hold during stalls.
// -----------------------------------------------------------------------------
module tb_prio_encoder_pipe;

    typedef struct packed {
        logic [1:0] code;
        logic       zero;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_vec;
    logic       out_ready;

    logic       in_ready_hi, out_valid_hi, out_zero_hi, out_multi_hi;
    logic [1:0] out_code_hi;
    logic       in_ready_lo, out_valid_lo, out_zero_lo, out_multi_lo;
    logic [1:0] out_code_lo;

    int total = 0;
    int bad   = 0;

    exp_t q_hi[$];
    exp_t q_lo[$];

    prio_encoder_pipe #(.N(4), .PRIO_HI(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_hi), .in_vec(in_vec),
        .out_valid(out_valid_hi), .out_ready(out_ready),
        .out_code(out_code_hi), .out_zero(out_zero_hi), .out_multi(out_multi_hi)
    );

    prio_encoder_pipe #(.N(4), .PRIO_HI(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_lo), .in_vec(in_vec),
        .out_valid(out_valid_lo), .out_ready(out_ready),
        .out_code(out_code_lo), .out_zero(out_zero_lo), .out_multi(out_multi_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int code, input bit zero, input bit multi);
        exp_t e;
        e.code  = 2'(code);
        e.zero  = zero;
        e.multi = multi;
        return e;
    endfunction

    // Reference model used for random vectors.
    function automatic exp_t model(input logic [3:0] v, input bit hi);
        exp_t e;
        e = '0;
        if (hi) begin
            for (int i = 3; i >= 0; i--) if (v[i]) begin e.code = 2'(i); break; end
        end else begin
            for (int i = 0; i < 4; i++) if (v[i]) begin e.code = 2'(i); break; end
        end
        e.zero  = (v == 4'b0000);
        e.multi = ($countones(v) > 1);
        return e;
    endfunction

    // ---------------- monitors ----------------
    exp_t held_hi, held_lo, e_hi, e_lo;
    bit   held_hi_v = 1'b0;
    bit   held_lo_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_hi_v = 1'b0;
        end else begin
            if (held_hi_v && out_valid_hi) begin
                check("hi_stall_code", out_code_hi, held_hi.code);
                check("hi_stall_flags", {out_zero_hi, out_multi_hi}, {held_hi.zero, held_hi.multi});
            end
            if (out_valid_hi && out_ready) begin
                held_hi_v = 1'b0;
                if (q_hi.size() == 0) begin
                    check("hi_unexpected_output", 1, 0);
                end else begin
                    e_hi = q_hi.pop_front();
                    check("hi_code", out_code_hi, e_hi.code);
                    check("hi_zero", out_zero_hi, e_hi.zero);
                    check("hi_multi", out_multi_hi, e_hi.multi);
                end
            end else if (out_valid_hi) begin
                held_hi_v = 1'b1;
                held_hi   = {out_code_hi, out_zero_hi, out_multi_hi};
            end else begin
                held_hi_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held_lo_v = 1'b0;
        end else begin
            if (held_lo_v && out_valid_lo) begin
                check("lo_stall_code", out_code_lo, held_lo.code);
                check("lo_stall_flags", {out_zero_lo, out_multi_lo}, {held_lo.zero, held_lo.multi});
            end
            if (out_valid_lo && out_ready) begin
                held_lo_v = 1'b0;
                if (q_lo.size() == 0) begin
                    check("lo_unexpected_output", 1, 0);
                end else begin
                    e_lo = q_lo.pop_front();
                    check("lo_code", out_code_lo, e_lo.code);
                    check("lo_zero", out_zero_lo, e_lo.zero);
                    check("lo_multi", out_multi_lo, e_lo.multi);
                end
            end else if (out_valid_lo) begin
                held_lo_v = 1'b1;
                held_lo   = {out_code_lo, out_zero_lo, out_multi_lo};
            end else begin
                held_lo_v = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    // Presents one vector until accepted; pushes expectations at acceptance.
    task automatic send(input logic [3:0] v, input exp_t eh, input exp_t el, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_vec   = v;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready_hi;
            if (acc) begin
                q_hi.push_back(eh);
                q_lo.push_back(el);
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    check("send_timeout", 0, 1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_vec   = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((q_hi.size() != 0) || (q_lo.size() != 0) || out_valid_hi) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                check(name, 0, 1);
                break;
            end
        end
    endtask

    logic [3:0] dir_vec [8] = '{4'b0000, 4'b0110, 4'b1111, 4'b1010,
                                4'b0011, 4'b1100, 4'b0101, 4'b1001};
    int         dir_hi  [8] = '{0, 2, 3, 3, 1, 3, 2, 3};
    int         dir_lo  [8] = '{0, 1, 0, 1, 0, 2, 0, 0};

    bit rand_done;

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 4'b0000;
        out_ready = 1'b1;
        rand_done = 1'b0;

        // 1: reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid_hi, 0);
        check("rst_in_ready", in_ready_hi, 1);
        check("rst_out_code", out_code_hi, 0);
        check("rst_flags", {out_zero_hi, out_multi_hi}, 0);
        check("rst_lo_valid", out_valid_lo, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2: one-hot sweep back-to-back, one-cycle latency, no stalls
        for (int i = 0; i < 4; i++) begin
            logic [3:0] v;
            v = 4'b0001 << i;
            send(v, mk(i, 0, 0), mk(i, 0, 0), w);
            check("sweep_no_wait", w, 0);
            check("sweep_latency_valid", out_valid_hi, 1);
            check("sweep_latency_code", out_code_hi, i);
        end
        wait_empty("sweep_drain_timeout");

        // 3: zero and multi-bit vectors
        for (int i = 0; i < 8; i++) begin
            send(dir_vec[i], mk(dir_hi[i], dir_vec[i] == 4'b0000, $countones(dir_vec[i]) > 1),
                             mk(dir_lo[i], dir_vec[i] == 4'b0000, $countones(dir_vec[i]) > 1), w);
        end
        wait_empty("multi_drain_timeout");

        // 4: backpressure fills both entries
        out_ready = 1'b0;
        send(4'b1000, mk(3, 0, 0), mk(3, 0, 0), w);
        send(4'b0010, mk(1, 0, 0), mk(1, 0, 0), w);
        @(negedge clk);
        check("bp_in_ready_low", in_ready_hi, 0);
        check("bp_out_code_held", out_code_hi, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_out_code_still", out_code_hi, 3);
        check("bp_in_ready_still_low", in_ready_hi, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_empty("bp_drain_timeout");
        @(negedge clk);
        check("bp_in_ready_back", in_ready_hi, 1);

        // 5: reset while both entries are occupied
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(4'b0001, mk(0, 0, 0), mk(0, 0, 0), w);
        send(4'b0010, mk(1, 0, 0), mk(1, 0, 0), w);
        check("mid_pre_in_ready", in_ready_hi, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_out_valid_async", out_valid_hi, 0);
        check("mid_in_ready_async", in_ready_hi, 1);
        check("mid_out_code_async", out_code_hi, 0);
        q_hi.delete();
        q_lo.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0100, mk(2, 0, 0), mk(2, 0, 0), w);
        check("mid_first_valid", out_valid_hi, 1);
        check("mid_first_code", out_code_hi, 2);
        wait_empty("mid_drain_timeout");

        // 6: random vectors with random valid gaps and ready toggling
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [3:0] v;
                    if ($urandom_range(0, 3) == 0) begin
                        in_vec = 4'($urandom_range(0, 15));
                        @(posedge clk);
                        #1;
                    end
                    v = 4'($urandom_range(0, 15));
                    send(v, model(v, 1'b1), model(v, 1'b0), w);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_empty("rand_drain_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
